// File: rtl/ring_code_decoder_pkg.sv
// Shared types and constants for the ring/Johnson code decoder.
// Imported by the decode sub-module and the top level.
package ring_code_decoder_pkg;

  localparam int MODE_RING    = 0;
  localparam int MODE_JOHNSON = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACQ,
    ST_LOCK
  } state_e;

  function automatic int calc_nst(input int width, input int mode);
    return (mode == MODE_JOHNSON) ? 2 * width : width;
  endfunction

endpackage

// File: rtl/ring_code_decode.sv
// Combinational code-word decoder: state word -> {legal, step index}.
// Covers both one-hot ring and Johnson (twisted ring) code sets.
module ring_code_decode
  import ring_code_decoder_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODE  = MODE_RING,
  parameter int IW    = 2
) (
  input  logic [WIDTH-1:0] code_i,
  output logic             legal_o,
  output logic [IW-1:0]    idx_o
);

  int ones;
  int trans;
  int idx_int;

  always_comb begin
    ones    = 0;
    trans   = 0;
    idx_int = 0;
    legal_o = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      ones += int'(code_i[i]);
    end
    if (MODE == MODE_RING) begin
      legal_o = (ones == 1);
      for (int p = 0; p < WIDTH; p++) begin
        if (code_i[p]) idx_int = (WIDTH - p) % WIDTH;
      end
    end else begin
      // A Johnson word has at most one 0/1 boundary between adjacent bits.
      for (int i = 0; i < WIDTH - 1; i++) begin
        if (code_i[i] != code_i[i+1]) trans++;
      end
      legal_o = (trans <= 1);
      if (code_i[WIDTH-1] || ones == 0) idx_int = ones;
      else                              idx_int = 2 * WIDTH - ones;
    end
    idx_o = IW'(idx_int);
  end

endmodule

// File: rtl/ring_code_decoder.sv
// Supervises a ring/Johnson counter: decodes its state word, checks the
// one-step advance, tracks lock and keeps a saturating error count.
module ring_code_decoder
  import ring_code_decoder_pkg::*;
#(
  parameter  int WIDTH    = 4,
  parameter  int MODE     = MODE_RING,
  parameter  int LOCK_CNT = 3,
  parameter  int ERR_W    = 8,
  localparam int NST      = calc_nst(WIDTH, MODE),
  localparam int IW       = ($clog2(NST) < 1) ? 1 : $clog2(NST)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] code_i,
  input  logic             ctr_rst_n_i,
  output logic [IW-1:0]    idx_o,
  output logic             idx_vld_o,
  output logic             locked_o,
  output logic             err_o,
  output logic             illegal_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  localparam int GW = $clog2(LOCK_CNT + 1);

  state_e             state_q, state_d;
  logic [IW-1:0]      prev_q, prev_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [GW-1:0]      good_cnt_q, good_cnt_d;
  logic               idx_vld_q, idx_vld_d;
  logic               err_q, err_d;
  logic               illegal_q, illegal_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

  logic               dec_legal;
  logic [IW-1:0]      dec_idx;
  logic [IW-1:0]      nxt_idx;
  logic [GW-1:0]      good_inc;
  logic               is_good;
  logic               is_stall;
  logic               is_rst_code;

  ring_code_decode #(
    .WIDTH (WIDTH),
    .MODE  (MODE),
    .IW    (IW)
  ) u_dec (
    .code_i  (code_i),
    .legal_o (dec_legal),
    .idx_o   (dec_idx)
  );

  always_comb begin
    nxt_idx     = (prev_q == IW'(NST - 1)) ? '0 : prev_q + IW'(1);
    good_inc    = good_cnt_q + GW'(1);
    is_good     = (dec_idx == nxt_idx);
    is_stall    = (dec_idx == prev_q);
    is_rst_code = dec_legal && (dec_idx == '0);

    state_d    = state_q;
    prev_d     = prev_q;
    idx_d      = idx_q;
    good_cnt_d = good_cnt_q;
    idx_vld_d  = idx_vld_q;
    err_d      = 1'b0;
    illegal_d  = 1'b0;

    if (!ctr_rst_n_i) begin
      // Counter held in reset: only its reset code is acceptable.
      if (is_rst_code) begin
        prev_d = '0;
        idx_d  = '0;
        if (state_q == ST_IDLE) begin
          state_d    = ST_ACQ;
          good_cnt_d = '0;
          idx_vld_d  = 1'b1;
        end
      end else begin
        illegal_d = 1'b1;
      end
    end else if (!dec_legal) begin
      illegal_d = 1'b1;
    end else begin
      idx_d = dec_idx;
      unique case (state_q)
        ST_IDLE: begin
          state_d    = ST_ACQ;
          prev_d     = dec_idx;
          good_cnt_d = '0;
          idx_vld_d  = 1'b1;
        end
        ST_ACQ: begin
          unique case (1'b1)
            is_good: begin
              prev_d     = dec_idx;
              good_cnt_d = good_inc;
              if (good_inc == GW'(LOCK_CNT)) state_d = ST_LOCK;
            end
            is_stall: ;
            default: begin
              err_d      = 1'b1;
              prev_d     = dec_idx;
              good_cnt_d = '0;
            end
          endcase
        end
        ST_LOCK: begin
          unique case (1'b1)
            is_good:  prev_d = dec_idx;
            is_stall: ;
            default: begin
              err_d      = 1'b1;
              state_d    = ST_ACQ;
              prev_d     = dec_idx;
              good_cnt_d = '0;
            end
          endcase
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (illegal_d) begin
      state_d    = ST_IDLE;
      idx_vld_d  = 1'b0;
      good_cnt_d = '0;
    end

    err_cnt_d = err_cnt_q;
    if ((err_d || illegal_d) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      prev_q     <= '0;
      idx_q      <= '0;
      good_cnt_q <= '0;
      idx_vld_q  <= 1'b0;
      err_q      <= 1'b0;
      illegal_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      idx_q      <= idx_d;
      good_cnt_q <= good_cnt_d;
      idx_vld_q  <= idx_vld_d;
      err_q      <= err_d;
      illegal_q  <= illegal_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign idx_o     = idx_q;
  assign idx_vld_o = idx_vld_q;
  assign locked_o  = (state_q == ST_LOCK);
  assign err_o     = err_q;
  assign illegal_o = illegal_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_ring_code_decoder.sv
// Directed bench: ring, Johnson and narrow-counter decoder instances.
module tb_ring_code_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [3:0] code_r, code_j, code_s;
  logic       crn_r, crn_j, crn_s;

  logic [1:0] idx_r;
  logic       vld_r, lock_r, err_r, ill_r;
  logic [7:0] cnt_r;
  logic [2:0] idx_j;
  logic       vld_j, lock_j, err_j, ill_j;
  logic [7:0] cnt_j;
  logic [1:0] idx_s;
  logic       vld_s, lock_s, err_s, ill_s;
  logic [1:0] cnt_s;

  int checks   = 0;
  int failures = 0;

  logic [3:0] ring_seq [5] = '{4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
  logic [3:0] john_seq [9] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111,
                               4'b0111, 4'b0011, 4'b0001, 4'b0000};
  logic [3:0] bad_seq  [5] = '{4'b0011, 4'b0101, 4'b0000, 4'b1111, 4'b0110};
  logic [1:0] sat_exp  [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  ring_code_decoder #(.WIDTH(4), .MODE(0), .LOCK_CNT(3), .ERR_W(8)) dut_r (
    .clk(clk), .reset(reset), .code_i(code_r), .ctr_rst_n_i(crn_r),
    .idx_o(idx_r), .idx_vld_o(vld_r), .locked_o(lock_r),
    .err_o(err_r), .illegal_o(ill_r), .err_cnt_o(cnt_r)
  );

  ring_code_decoder #(.WIDTH(4), .MODE(1), .LOCK_CNT(3), .ERR_W(8)) dut_j (
    .clk(clk), .reset(reset), .code_i(code_j), .ctr_rst_n_i(crn_j),
    .idx_o(idx_j), .idx_vld_o(vld_j), .locked_o(lock_j),
    .err_o(err_j), .illegal_o(ill_j), .err_cnt_o(cnt_j)
  );

  ring_code_decoder #(.WIDTH(4), .MODE(0), .LOCK_CNT(3), .ERR_W(2)) dut_s (
    .clk(clk), .reset(reset), .code_i(code_s), .ctr_rst_n_i(crn_s),
    .idx_o(idx_s), .idx_vld_o(vld_s), .locked_o(lock_s),
    .err_o(err_s), .illegal_o(ill_s), .err_cnt_o(cnt_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b0;
    code_r = 4'b0001;
    code_j = 4'b0000;
    code_s = 4'b0001;
    crn_r  = 1'b1;
    crn_j  = 1'b1;
    crn_s  = 1'b1;
    step();
    step();
    chk("rst_idx",  32'(idx_r),  0);
    chk("rst_vld",  32'(vld_r),  0);
    chk("rst_lock", 32'(lock_r), 0);
    chk("rst_err",  32'(err_r),  0);
    chk("rst_ill",  32'(ill_r),  0);
    chk("rst_cnt",  32'(cnt_r),  0);

    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      code_r = ring_seq[i];
      step();
      chk("ring_idx", 32'(idx_r), 32'(i % 4));
      chk("ring_vld", 32'(vld_r), 1);
      chk("ring_lock", 32'(lock_r), (i >= 3) ? 1 : 0);
      chk("ring_err", 32'({err_r, ill_r}), 0);
    end
    chk("ring_cnt0", 32'(cnt_r), 0);

    code_r = 4'b0011;
    step();
    chk("inj_ill",  32'(ill_r),  1);
    chk("inj_err",  32'(err_r),  0);
    chk("inj_cnt",  32'(cnt_r),  1);
    chk("inj_vld",  32'(vld_r),  0);
    chk("inj_lock", 32'(lock_r), 0);
    code_r = 4'b0100;
    step();
    chk("reacq_vld", 32'(vld_r), 1);
    chk("reacq_idx", 32'(idx_r), 2);
    chk("reacq_ill", 32'(ill_r), 0);

    code_r = 4'b0010; step();
    code_r = 4'b0001; step();
    code_r = 4'b1000; step();
    chk("lock1_lock", 32'(lock_r), 1);
    chk("lock1_idx",  32'(idx_r),  1);
    step();
    chk("stall_lock", 32'(lock_r), 1);
    chk("stall_err",  32'({err_r, ill_r}), 0);

    code_r = 4'b0010;
    step();
    chk("skip_err",  32'(err_r),  1);
    chk("skip_ill",  32'(ill_r),  0);
    chk("skip_lock", 32'(lock_r), 0);
    chk("skip_cnt",  32'(cnt_r),  2);
    chk("skip_idx",  32'(idx_r),  3);
    code_r = 4'b0001; step();
    chk("relock_err", 32'(err_r), 0);
    code_r = 4'b1000; step();
    chk("relock_l2", 32'(lock_r), 0);
    code_r = 4'b0100; step();
    chk("relock_l3", 32'(lock_r), 1);
    chk("relock_idx", 32'(idx_r), 2);

    crn_r  = 1'b0;
    code_r = 4'b0001;
    step();
    chk("crst_idx",  32'(idx_r),  0);
    chk("crst_err",  32'({err_r, ill_r}), 0);
    chk("crst_lock", 32'(lock_r), 1);
    chk("crst_cnt",  32'(cnt_r),  2);
    crn_r  = 1'b1;
    code_r = 4'b1000;
    step();
    chk("crst_next", 32'(idx_r), 1);
    chk("crst_nlk",  32'(lock_r), 1);
    crn_r  = 1'b0;
    code_r = 4'b0100;
    step();
    chk("crst_bad_ill",  32'(ill_r),  1);
    chk("crst_bad_lock", 32'(lock_r), 0);
    chk("crst_bad_cnt",  32'(cnt_r),  3);
    crn_r = 1'b1;

    for (int i = 0; i < 9; i++) begin
      code_j = john_seq[i];
      step();
      chk("john_idx", 32'(idx_j), 32'(i % 8));
      chk("john_err", 32'({err_j, ill_j}), 0);
      if (i == 2) chk("john_lock_pre", 32'(lock_j), 0);
      if (i >= 3) chk("john_lock", 32'(lock_j), 1);
    end
    code_j = 4'b1010;
    step();
    chk("john_ill",  32'(ill_j), 1);
    chk("john_cnt",  32'(cnt_j), 1);
    chk("john_vld",  32'(vld_j), 0);

    for (int i = 0; i < 5; i++) begin
      code_s = bad_seq[i];
      step();
      chk("sat_ill", 32'(ill_s), 1);
      chk("sat_cnt", 32'(cnt_s), 32'(sat_exp[i]));
    end
    code_s = 4'b0001;
    step();
    chk("sat_vld", 32'(vld_s), 1);
    chk("sat_hold", 32'(cnt_s), 3);

    reset  = 1'b0;
    code_s = 4'b1000;
    step();
    chk("mrst_s", 32'({idx_s, vld_s, lock_s, err_s, ill_s, cnt_s}), 0);
    chk("mrst_r", 32'({idx_r, vld_r, lock_r, err_r, ill_r, cnt_r}), 0);
    chk("mrst_j", 32'({idx_j, vld_j, lock_j, err_j, ill_j, cnt_j}), 0);
    reset = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
